cam_capture_rgb444: RTL and testbench

- Upstream stage of the frame processor: captures one QQVGA frame from an OV7670-style parallel camera bus (RGB565, two bytes per pixel).
- Converts each pixel to RGB444 and writes it sequentially into the frame buffer that the processing block later reads.
- Software or the top level asks for a frame with capture_req; the block reports completion and frame integrity.

---
 rtl/cam_capture_rgb444.sv | 177 +++++++++++++++++
 tb/tb_cam_capture_rgb444.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_rgb444.sv
// Captures one RGB565 frame from an OV7670-style bus into an RGB444 frame buffer.
// Optional CAPTURE_TEST_PATTERN_EN adds test_mode, which substitutes a 4-bar column pattern.
module cam_capture_rgb444 #(
    parameter int M  = 160,
    parameter int N  = 120,
    parameter int AW = 15,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_req,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
`ifdef CAPTURE_TEST_PATTERN_EN
    input  logic          test_mode,
`endif
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          ready,
    output logic          frame_ok
);

    localparam logic [AW-1:0] FRAME_PIX = AW'(M * N);
    localparam logic [8:0]    LINE_PIX  = 9'(M);
    localparam logic [8:0]    COL_MAX   = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        CAPTURE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic          phase;
    logic [6:0]    byte1;
    logic [AW-1:0] pix_cnt;
    logic [8:0]    col_cnt;
    logic          err;
    logic          vsync_d;
    logic          href_d;

    logic          vs_rise;
    logic          href_fall;
    logic          line_err;
    logic          pix_full;
    logic [DW-1:0] pix_cam;
    logic [DW-1:0] pix;
    logic          unused_bits;

    assign vs_rise   = cam_vsync & ~vsync_d;
    assign href_fall = ~cam_href & href_d;
    assign line_err  = href_fall & ((col_cnt != LINE_PIX) | phase);
    assign pix_full  = (pix_cnt == FRAME_PIX);

    // byte1 keeps only R[3:0] and G[3:1]; G[0] and B come from byte2
    assign pix_cam = DW'({byte1[6:3], byte1[2:0], cam_data[7], cam_data[4:1]});
    assign unused_bits = ^{cam_data[6:5], cam_data[0]};

`ifdef CAPTURE_TEST_PATTERN_EN
    logic [DW-1:0] pix_tp;

    always_comb begin
        pix_tp = DW'(12'h000);
        if (col_cnt < 9'(M / 4))
            pix_tp = DW'(12'hF00);
        else if (col_cnt < 9'(M / 2))
            pix_tp = DW'(12'h0F0);
        else if (col_cnt < 9'((3 * M) / 4))
            pix_tp = DW'(12'h00F);
    end

    assign pix = test_mode ? pix_tp : pix_cam;
`else
    assign pix = pix_cam;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (capture_req) state_nx = WAIT_VS_HIGH;
            WAIT_VS_HIGH: if (cam_vsync)   state_nx = WAIT_VS_LOW;
            WAIT_VS_LOW:  if (!cam_vsync)  state_nx = CAPTURE;
            CAPTURE:      if (vs_rise)     state_nx = DONE;
            DONE:         if (!capture_req) state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            ready      <= 1'b0;
            frame_ok   <= 1'b0;
            phase      <= 1'b0;
            byte1      <= '0;
            pix_cnt    <= '0;
            col_cnt    <= '0;
            err        <= 1'b0;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture_req) begin
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        frame_ok <= 1'b0;
                    end
                end
                WAIT_VS_LOW: begin
                    if (!cam_vsync) begin
                        pix_cnt <= '0;
                        col_cnt <= '0;
                        err     <= 1'b0;
                        phase   <= 1'b0;
                        wr_addr <= '0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        ready      <= 1'b1;
                        frame_ok   <= pix_full & ~err & ~line_err;
                    end else if (cam_href) begin
                        if (!phase) begin
                            byte1 <= {cam_data[7:4], cam_data[2:0]};
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (col_cnt != COL_MAX)
                                col_cnt <= col_cnt + 9'd1;
                            if (!pix_full) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_cnt;
                                wr_data <= pix;
                                pix_cnt <= pix_cnt + 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        // a dangling odd byte is dropped with the line
                        if (line_err)
                            err <= 1'b1;
                        phase   <= 1'b0;
                        col_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Directed bench for cam_capture_rgb444 on a reduced 16x6 frame.
// Each expected value is hand-derived from the RGB565->RGB444 mapping.
module tb_cam_capture_rgb444;

    localparam int M  = 16;
    localparam int N  = 6;
    localparam int AW = 15;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          capture_req = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          test_mode = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic          ready;
    logic          frame_ok;

    cam_capture_rgb444 #(.M(M), .N(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_req (capture_req),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
`ifdef CAPTURE_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .ready       (ready),
        .frame_ok    (frame_ok)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    logic [DW-1:0] exp_data = '0;
    bit            tp_on = 1'b0;

    int nwr = 0;
    int zero_cnt = 0;
    int addr_err = 0;
    int data_err = 0;
    int done_cnt = 0;
    int last_addr = 0;

    int s_wr, s_zero, s_addr, s_data, s_done;

    function automatic logic [DW-1:0] bar(input int col);
        if (col < 4)       return 12'hF00;
        else if (col < 8)  return 12'h0F0;
        else if (col < 12) return 12'h00F;
        else               return 12'h000;
    endfunction

    always @(negedge clk) begin
        if (frame_done)
            done_cnt++;
        if (wr_en) begin
            if (wr_addr == '0)
                zero_cnt++;
            else if (int'(wr_addr) != last_addr + 1)
                addr_err++;
            if (wr_data != (tp_on ? bar(int'(wr_addr) % M) : exp_data))
                data_err++;
            last_addr = int'(wr_addr);
            nwr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_wr   = nwr;
        s_zero = zero_cnt;
        s_addr = addr_err;
        s_data = data_err;
        s_done = done_cnt;
    endtask

    task automatic send_line(input int npix, input logic [7:0] b1,
                             input logic [7:0] b2);
        for (int i = 0; i < npix; i++) begin
            cam_href = 1'b1;
            cam_data = b1;
            @(negedge clk);
            cam_data = b2;
            @(negedge clk);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int nlines, input int short_ln,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input bit want_done);
        bit got;
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nlines; l++)
            send_line((l == short_ln) ? M - 1 : M, b1, b2);
        cam_vsync = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (frame_done)
                got = 1'b1;
        end
        if (want_done)
            check("done_seen", {31'd0, got}, 1);
        repeat (2) @(negedge clk);
        cam_vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic arm();
        bit got;
        capture_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            @(negedge clk);
            if (busy)
                got = 1'b1;
        end
        check("arm_busy", {31'd0, got}, 1);
    endtask

    task automatic release_req();
        capture_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_checks(input string tag, input int exp_wr,
                                input int exp_last, input bit exp_ok);
        check({tag, "_writes"}, nwr - s_wr, exp_wr);
        check({tag, "_zero"}, zero_cnt - s_zero, 1);
        check({tag, "_seq"}, addr_err - s_addr, 0);
        check({tag, "_last"}, last_addr, exp_last);
        check({tag, "_data"}, data_err - s_data, 0);
        check({tag, "_done"}, done_cnt - s_done, 1);
        check({tag, "_ok"}, {31'd0, frame_ok}, {31'd0, exp_ok});
        check({tag, "_ready"}, {31'd0, ready}, 1);
        check({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int pre;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, frame_done}, 0);
        check("rst_ready", {31'd0, ready}, 0);
        check("rst_ok", {31'd0, frame_ok}, 0);

        // ideal frame, 0xF8,0x00 -> F00
        exp_data = 12'hF00;
        snap();
        arm();
        check("arm_ready_clr", {31'd0, ready}, 0);
        run_frame(N, -1, 8'hF8, 8'h00, 1'b1);
        frame_checks("ideal", M * N, M * N - 1, 1'b1);
        release_req();

        // byte mapping
        exp_data = 12'h0F0;
        snap();
        arm();
        run_frame(N, -1, 8'h07, 8'hE0, 1'b1);
        frame_checks("map_0f0", M * N, M * N - 1, 1'b1);
        release_req();

        exp_data = 12'h00F;
        snap();
        arm();
        run_frame(N, -1, 8'h00, 8'h1F, 1'b1);
        frame_checks("map_00f", M * N, M * N - 1, 1'b1);
        release_req();

        // arm while lines are flowing with vsync low
        exp_data = 12'hF00;
        snap();
        send_line(M, 8'hF8, 8'h00);
        capture_req = 1'b1;
        send_line(M, 8'hF8, 8'h00);
        send_line(M, 8'hF8, 8'h00);
        check("mid_busy", {31'd0, busy}, 1);
        check("mid_no_wr", nwr - s_wr, 0);
        run_frame(N, -1, 8'hF8, 8'h00, 1'b1);
        frame_checks("mid", M * N, M * N - 1, 1'b1);
        release_req();

        // short line 2
        snap();
        arm();
        run_frame(N, 2, 8'hF8, 8'h00, 1'b1);
        frame_checks("short", M * N - 1, M * N - 2, 1'b0);
        release_req();

        // overlong frame
        snap();
        arm();
        run_frame(N + 1, -1, 8'hF8, 8'h00, 1'b1);
        frame_checks("long", M * N, M * N - 1, 1'b0);
        release_req();

        // reset in the middle of line 3
        snap();
        arm();
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (2) @(negedge clk);
        send_line(M, 8'hF8, 8'h00);
        send_line(M, 8'hF8, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cam_href = 1'b1;
            cam_data = 8'hF8;
            @(negedge clk);
            cam_data = 8'h00;
            @(negedge clk);
        end
        cam_data = 8'hF8;
        rst = 1'b1;
        capture_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_pre", {31'd0, (nwr - s_wr) >= 2 * M}, 1);
        check("rst_mid_wr_en", {31'd0, wr_en}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_ready", {31'd0, ready}, 0);
        pre = nwr;
        cam_data = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cam_data = 8'hF8;
            @(negedge clk);
            cam_data = 8'h00;
            @(negedge clk);
        end
        cam_href = 1'b0;
        repeat (2) @(negedge clk);
        send_line(M, 8'hF8, 8'h00);
        cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        cam_vsync = 1'b0;
        @(negedge clk);
        check("rst_mid_no_wr", nwr - pre, 0);
        check("rst_mid_idle_busy", {31'd0, busy}, 0);

        // re-arm: held high does not retrigger
        snap();
        arm();
        run_frame(N, -1, 8'hF8, 8'h00, 1'b1);
        frame_checks("rearm1", M * N, M * N - 1, 1'b1);
        snap();
        run_frame(N, -1, 8'hF8, 8'h00, 1'b0);
        check("held_no_wr", nwr - s_wr, 0);
        check("held_no_done", done_cnt - s_done, 0);
        check("held_busy", {31'd0, busy}, 0);
        check("held_ready", {31'd0, ready}, 1);
        release_req();
        snap();
        arm();
        run_frame(N, -1, 8'hF8, 8'h00, 1'b1);
        frame_checks("rearm2", M * N, M * N - 1, 1'b1);
        release_req();

`ifdef CAPTURE_TEST_PATTERN_EN
        test_mode = 1'b1;
        tp_on = 1'b1;
        snap();
        arm();
        run_frame(N, -1, 8'h5A, 8'hA5, 1'b1);
        frame_checks("tpat", M * N, M * N - 1, 1'b1);
        release_req();
        tp_on = 1'b0;
        test_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
